// File: rtl/avg_sample_loader_pkg.sv
// avg_sample_loader_pkg: shared widths, window size, latency default and FSM encoding
package avg_sample_loader_pkg;
  localparam int DATAWIDTH = 16;
  localparam int NSAMP = 8;
  localparam int LATENCY = 8;
  localparam int IDXW = $clog2(NSAMP);
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int timer_w(input int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/avg_sample_loader_if.sv
// avg_sample_loader_if: sample stream in, presented window out
interface avg_sample_loader_if #(parameter int DW = 16);
  logic [DW-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic flush;
  logic [DW-1:0] cfg_num;
  logic [DW-1:0] a, b, c, d, e, f, g, h, num;
  logic win_busy;
  logic avg_valid;
  logic [15:0] win_count;
  modport master (
    output s_data, s_valid, flush, cfg_num,
    input s_ready, a, b, c, d, e, f, g, h, num, win_busy, avg_valid, win_count
  );
  modport slave (
    input s_data, s_valid, flush, cfg_num,
    output s_ready, a, b, c, d, e, f, g, h, num, win_busy, avg_valid, win_count
  );
endinterface

// File: rtl/avg_sample_loader_sample_bank.sv
// avg_sample_loader_sample_bank: NSAMP-entry fill register file, indexed write, parallel read
module avg_sample_loader_sample_bank
  import avg_sample_loader_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic we,
  input  logic [IDXW-1:0] widx,
  input  logic [DW-1:0] wdata,
  output logic [NSAMP-1:0][DW-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (we) q[widx] <= wdata;
endmodule

// File: rtl/avg_sample_loader.sv
// avg_sample_loader: gathers 8-sample windows from a stream and holds each for the
// averaging pipeline latency, flagging avg_valid when the consumer result is ready
module avg_sample_loader #(
  parameter int DATAWIDTH = avg_sample_loader_pkg::DATAWIDTH,
  parameter int LATENCY = avg_sample_loader_pkg::LATENCY
) (
  input logic clk,
  input logic rst,
  avg_sample_loader_if.slave bus
);
  import avg_sample_loader_pkg::*;
  localparam int TW = timer_w(LATENCY);
  localparam logic [TW-1:0] TLAST = TW'(LATENCY - 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [IDXW-1:0] idx;
  logic fill_full;
  logic [NSAMP-1:0][DATAWIDTH-1:0] fill;
  logic xfer, last, launch, full_nxt;
  assign xfer = bus.s_valid & bus.s_ready & ~bus.flush;
  assign last = state == HOLD && timer == TLAST;
  // flush outranks launch so a full but unlaunched window is discarded
  assign launch = fill_full & ~bus.flush & (state == IDLE | last);
  assign full_nxt = bus.flush ? 1'b0 : launch ? 1'b0 :
                    (xfer && idx == IDXW'(NSAMP - 1)) ? 1'b1 : fill_full;
  assign bus.win_busy = state == HOLD;
  avg_sample_loader_sample_bank #(.DW(DATAWIDTH)) u_bank (
    .clk(clk),
    .rst(rst),
    .clr(bus.flush),
    .we(xfer),
    .widx(idx),
    .wdata(bus.s_data),
    .q(fill)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      fill_full <= 1'b0;
      bus.s_ready <= 1'b0;
      bus.avg_valid <= 1'b0;
      bus.win_count <= '0;
      {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h, bus.num} <= '0;
    end else begin
      idx <= bus.flush ? '0 : xfer ? idx + 1'b1 : idx;
      fill_full <= full_nxt;
      bus.s_ready <= ~full_nxt;
      bus.avg_valid <= last;
      bus.win_count <= last ? bus.win_count + 16'd1 : bus.win_count;
      timer <= launch ? '0 : state == HOLD ? timer + 1'b1 : timer;
      state <= launch ? HOLD : last ? IDLE : state;
      if (launch) begin
        {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} <= fill;
        bus.num <= bus.cfg_num;
      end
    end
endmodule

// File: tb/tb_avg_sample_loader.sv
// tb_avg_sample_loader: directed and random stimulus against a window-scheduling reference model
module tb_avg_sample_loader;
  localparam int LAT = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int k = 0;
  logic [15:0] q_part[$];
  logic m_pend = 1'b0, m_act = 1'b0, m_avg = 1'b0, m_rdy = 1'b0;
  logic [127:0] m_pw = '0, m_cur = '0;
  logic [15:0] m_num = '0, m_cnt = '0;
  int m_p = 0;
  avg_sample_loader_if #(.DW(16)) bus ();
  avg_sample_loader #(.DATAWIDTH(16), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, o, e, k);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] d, input logic fl, output logic acc);
    logic la, ev;
    bus.s_valid = v;
    bus.s_data = d;
    bus.flush = fl;
    acc = v && m_rdy && rst && !fl;
    @(posedge clk);
    #1;
    k++;
    if (!rst) begin
      q_part.delete();
      {m_pend, m_act, m_avg, m_rdy} = '0;
      m_cur = '0;
      m_num = '0;
      m_cnt = '0;
      acc = 1'b0;
    end else begin
      ev = m_act && k == m_p + LAT;
      la = m_pend && !fl && (!m_act || ev);
      if (fl) m_pend = 1'b0;
      if (la) begin
        m_cur = m_pw;
        m_num = bus.cfg_num;
        m_p = k;
        m_pend = 1'b0;
      end
      m_avg = ev;
      if (ev) m_cnt++;
      m_act = la ? 1'b1 : ev ? 1'b0 : m_act;
      if (fl) q_part.delete();
      else if (acc) begin
        q_part.push_back(d);
        if (q_part.size() == 8) begin
          m_pw = {q_part[0], q_part[1], q_part[2], q_part[3], q_part[4], q_part[5], q_part[6], q_part[7]};
          m_pend = 1'b1;
          q_part.delete();
        end
      end
      m_rdy = !m_pend;
    end
    chk("window", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h}, m_cur);
    chk("num", 128'(bus.num), 128'(m_num));
    chk("s_ready", 128'(bus.s_ready), 128'(m_rdy));
    chk("win_busy", 128'(bus.win_busy), 128'(m_act));
    chk("avg_valid", 128'(bus.avg_valid), 128'(m_avg));
    chk("win_count", 128'(bus.win_count), 128'(m_cnt));
  endtask
  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, 16'h0, 1'b0, acc);
  endtask
  task automatic feed(input int n, input int base, input int gap);
    logic acc;
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      cyc(1'b1, 16'(base + i), 1'b0, acc);
      if (acc) i++;
      guard++;
      repeat (gap) cyc(1'b0, 16'h0, 1'b0, acc);
    end
    tests++;
    assert (i == n) else begin
      fails++;
      $error("FAIL feed_bound: got %0d accepted expected %0d", i, n);
    end
  endtask
  initial begin
    logic acc;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.flush = 1'b0;
    bus.cfg_num = 16'd8;
    idle(3);
    rst = 1'b1;
    idle(2);
    feed(8, 1, 0);
    idle(4);
    chk("avg_36_div_8", 128'(({16'h0, bus.a} + bus.b + bus.c + bus.d + bus.e + bus.f + bus.g + bus.h) / bus.num), 128'd4);
    idle(12);
    feed(24, 1, 0);
    idle(30);
    feed(5, 100, 0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    feed(8, 10, 0);
    idle(15);
    feed(8, 1, 2);
    idle(12);
    feed(8, 1, 2);
    idle(12);
    feed(8, 40, 0);
    feed(8, 50, 0);
    cyc(1'b1, 16'd99, 1'b1, acc);
    idle(20);
    feed(8, 60, 0);
    idle(3);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(12);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 49) == 0) bus.cfg_num = 16'($urandom);
      cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 39) == 0, acc);
    end
    idle(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
